// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared definitions for the 2x2 master/slave crossbar: arbiter state
// encoding, the address bit that selects the slave port, and the default
// slave-response timeout used by the arbiter and the master-side blocks.
// No ports (package).
// ---------------------------------------------------------------------------
package xbar_pkg;

    // Arbiter state encoding.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_BUSY_ENC = 2'd1;
    localparam logic [1:0] ST_GAP_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_BUSY = ST_BUSY_ENC,
        ST_GAP  = ST_GAP_ENC
    } state_t;

    // Master address bit that decodes to a slave port (fed in as m_sel).
    localparam int SLAVE_SEL_BIT = 31;

    // Default cycles to wait for a slave ack, and a counter width holding it.
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_TOUT_W  = 8;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// xbar_slave_arbiter_if
// Bundle between the masters' request side and one slave arbiter.
//   m_req / m_sel : per-master request level and addr[31] decode value
//   s_ack         : slave acknowledge pulse
//   s_req         : request to the slave, high while a grant is held
//   grant         : one-hot owner, grant_idx its binary index
//   m_ack / m_err : ack / timeout pulse routed to the owner
// Modport slave is taken by the arbiter, modport master by whoever drives
// the requests (crossbar top or testbench).
// ---------------------------------------------------------------------------
interface xbar_slave_arbiter_if
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 2
);
    localparam int IDX_W = idx_w(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] m_req;
    logic [NUM_MASTERS-1:0] m_sel;
    logic                   s_ack;
    logic                   s_req;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_MASTERS-1:0] m_ack;
    logic [NUM_MASTERS-1:0] m_err;

    modport slave (
        input  m_req, m_sel, s_ack,
        output s_req, grant, grant_idx, m_ack, m_err
    );

    modport master (
        output m_req, m_sel, s_ack,
        input  s_req, grant, grant_idx, m_ack, m_err
    );

endinterface

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin pick: the first set bit of 'eligible' at or after
// (ptr+1) mod N, wrapping around.
//   eligible   in  N      candidate vector
//   ptr        in  IDX_W  index of the previous winner
//   winner     out N      one-hot winner (zero when nothing eligible)
//   winner_idx out IDX_W  binary index of the winner (zero when none)
//   any_valid  out 1      some bit of eligible is set
// ---------------------------------------------------------------------------
module rr_picker
    import xbar_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_valid
);

    logic [N-1:0]   above_ptr;
    logic [2*N-1:0] dbl;
    logic           found;

    // Low half: only candidates strictly above ptr. High half: all of them.
    // The lowest set bit of the concatenation is the round-robin winner, and
    // the high half supplies the wrap-around case.
    always_comb begin
        above_ptr  = '0;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            above_ptr[i] = (i > int'(ptr));
        end
        dbl = {eligible, eligible & above_ptr};
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found      = 1'b1;
                winner_idx = IDX_W'(i % N);
            end
        end
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
        any_valid = found;
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_slave_arbiter
// Per-slave arbiter of the 2x2 crossbar. Picks an eligible master round robin,
// holds the grant until the slave acks, the owner drops its request, or the
// slave times out, then leaves one idle cycle before the next grant.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : xbar_slave_arbiter_if.slave (requests in, grant/ack/err out)
//   dbg_state  : current FSM state for observation
// A master is eligible when m_req[i] is high and m_sel[i] (its addr[31])
// equals SLAVE_ID.
// ---------------------------------------------------------------------------
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int   NUM_MASTERS = 2,
    parameter logic SLAVE_ID    = 1'b0,
    parameter int   TIMEOUT     = DEF_TIMEOUT,
    parameter int   TOUT_W      = DEF_TOUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    xbar_slave_arbiter_if.slave   bus,
    output state_t                dbg_state
);

    localparam int                IDX_W    = idx_w(NUM_MASTERS);
    localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(NUM_MASTERS - 1);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [TOUT_W-1:0]      tout_q, tout_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;

    logic owner_req;
    logic ack_hit;
    logic drop_hit;
    logic tout_hit;

    always_comb begin
        eligible = bus.m_req & ~(bus.m_sel ^ {NUM_MASTERS{SLAVE_ID}});
    end

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible   (eligible),
        .ptr        (ptr_q),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any_valid  (win_any)
    );

    // End-of-transaction events, mutually exclusive by priority:
    // ack beats request drop, request drop beats timeout.
    always_comb begin
        owner_req = bus.m_req[idx_q];
        ack_hit   = (state_q == ST_BUSY) && bus.s_ack;
        drop_hit  = (state_q == ST_BUSY) && !bus.s_ack && !owner_req;
        tout_hit  = (state_q == ST_BUSY) && !bus.s_ack && owner_req
                    && (tout_q == TOUT_MAX);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        tout_d  = tout_q;
        case (state_q)
            // GAP already drives grant=0 for its single cycle, so it
            // arbitrates exactly like IDLE; that is what makes an ack in
            // cycle k yield the next grant in cycle k+2. IDLE is where the
            // FSM rests when nobody was eligible.
            ST_IDLE, ST_GAP: begin
                if (win_any) begin
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    tout_d  = '0;
                    state_d = ST_BUSY;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_hit || drop_hit || tout_hit) begin
                    grant_d = '0;
                    state_d = ST_GAP;
                end else if (tout_q != TOUT_MAX) begin
                    tout_d = tout_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tout_q  <= tout_d;
        end
    end

    // Ack and error are combinational off the held grant; they are masked
    // during reset so an abort by reset never looks like a completion.
    assign bus.s_req     = |grant_q;
    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.m_ack     = grant_q & {NUM_MASTERS{ack_hit && !rst}};
    assign bus.m_err     = grant_q & {NUM_MASTERS{tout_hit && !rst}};
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_slave_arbiter
// Directed bench for xbar_slave_arbiter (NUM_MASTERS=2, SLAVE_ID=0,
// TIMEOUT=4). Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_xbar_slave_arbiter;
    import xbar_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int n_total;
    int n_bad;
    int waited;
    int cnt0;
    int cnt1;
    logic [1:0] exp_g;
    logic [1:0] exp_q[$];

    xbar_slave_arbiter_if #(.NUM_MASTERS(2)) bus ();

    xbar_slave_arbiter #(
        .NUM_MASTERS (2),
        .SLAVE_ID    (1'b0),
        .TIMEOUT     (4),
        .TOUT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=no_finish expected=finish_before_100us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        cnt0        = 0;
        cnt1        = 0;
        rst         = 1'b1;
        bus.m_req   = 2'b00;
        bus.m_sel   = 2'b00;
        bus.s_ack   = 1'b0;
        repeat (3) tick();

        // Reset state.
        check_eq("rst_s_req", bus.s_req, 0);
        check_eq("rst_grant", bus.grant, 0);
        check_eq("rst_grant_idx", bus.grant_idx, 0);
        check_eq("rst_m_err", bus.m_err, 0);
        check_eq("rst_m_ack", bus.m_ack, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);

        // T1: both request slave 0; cycle 0 is the first cycle out of reset.
        rst       = 1'b0;
        bus.m_req = 2'b11;
        bus.m_sel = 2'b00;
        #1;
        check_eq("t1_c0_grant", bus.grant, 0);
        tick();                                    // cycle 1
        check_eq("t1_c1_grant", bus.grant, 2'b01);
        check_eq("t1_c1_s_req", bus.s_req, 1);
        check_eq("t1_c1_idx", bus.grant_idx, 0);
        check_eq("t1_c1_state", dbg_state, ST_BUSY);
        tick();                                    // cycle 2
        check_eq("t1_c2_grant", bus.grant, 2'b01);
        tick();                                    // cycle 3
        bus.s_ack = 1'b1;
        #1;
        check_eq("t1_c3_m_ack", bus.m_ack, 2'b01);
        check_eq("t1_c3_m_err", bus.m_err, 0);
        tick();                                    // cycle 4
        bus.s_ack = 1'b0;
        #1;
        check_eq("t1_c4_grant", bus.grant, 0);
        check_eq("t1_c4_s_req", bus.s_req, 0);
        check_eq("t1_c4_m_ack", bus.m_ack, 0);
        check_eq("t1_c4_state", dbg_state, ST_GAP);
        tick();                                    // cycle 5
        check_eq("t1_c5_grant", bus.grant, 2'b10);
        check_eq("t1_c5_idx", bus.grant_idx, 1);
        // Owner m1 drops its request: abort without ack or error.
        bus.m_req = 2'b00;
        #1;
        check_eq("t1_drop_m_ack", bus.m_ack, 0);
        check_eq("t1_drop_m_err", bus.m_err, 0);
        tick();
        check_eq("t1_drop_state", dbg_state, ST_GAP);
        check_eq("t1_drop_grant", bus.grant, 0);
        tick();
        check_eq("t1_idle_state", dbg_state, ST_IDLE);

        // T2: only m1 requests but decodes to slave 1; stray acks ignored.
        bus.m_req = 2'b10;
        bus.m_sel = 2'b10;
        for (int i = 0; i < 20; i++) begin
            bus.s_ack = (i % 3 == 0);
            #1;
            check_eq("t2_grant", bus.grant, 0);
            check_eq("t2_s_req", bus.s_req, 0);
            check_eq("t2_m_ack", bus.m_ack, 0);
            tick();
        end
        bus.s_ack = 1'b0;
        check_eq("t2_state", dbg_state, ST_IDLE);

        // T3: m0 owns the slave and is never acked -> error after 4 cycles.
        bus.m_req = 2'b01;
        bus.m_sel = 2'b00;
        tick();                                    // grant cycle g
        check_eq("t3_grant", bus.grant, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_no_err", bus.m_err, 0);
            tick();
        end                                        // now g+4
        check_eq("t3_m_err", bus.m_err, 2'b01);
        check_eq("t3_err_grant", bus.grant, 2'b01);
        check_eq("t3_err_m_ack", bus.m_ack, 0);
        tick();                                    // g+5
        check_eq("t3_gap_state", dbg_state, ST_GAP);
        check_eq("t3_gap_m_err", bus.m_err, 0);
        check_eq("t3_gap_grant", bus.grant, 0);
        tick();                                    // g+6
        check_eq("t3_regrant", bus.grant, 2'b01);

        // T4: owner drops its request in the same cycle the slave acks.
        bus.m_req = 2'b00;
        bus.s_ack = 1'b1;
        #1;
        check_eq("t4_m_ack", bus.m_ack, 2'b01);
        check_eq("t4_m_err", bus.m_err, 0);
        tick();
        bus.s_ack = 1'b0;
        check_eq("t4_state", dbg_state, ST_GAP);

        // T5: both request continuously, ack on every 2nd BUSY cycle.
        // m0 won last, so m1 leads and the owners alternate.
        bus.m_req = 2'b11;
        for (int t = 0; t < 100; t++) begin
            exp_q.push_back((t % 2 == 0) ? 2'b10 : 2'b01);
        end
        for (int t = 0; t < 100; t++) begin
            waited = 0;
            while (!bus.s_req && waited < 4) begin
                tick();
                waited++;
            end
            exp_g = exp_q.pop_front();
            check_eq("t5_s_req", bus.s_req, 1);
            check_eq("t5_gap_len", waited, 1);
            check_eq("t5_grant", bus.grant, exp_g);
            if (bus.grant_idx == 1'b1) cnt1++;
            else cnt0++;
            tick();
            bus.s_ack = 1'b1;
            #1;
            check_eq("t5_m_ack", bus.m_ack, exp_g);
            tick();
            bus.s_ack = 1'b0;
        end
        bus.m_req = 2'b00;
        check_eq("t5_cnt_m0", cnt0, 50);
        check_eq("t5_cnt_m1", cnt1, 50);
        check_eq("t5_q_empty", exp_q.size(), 0);

        // T6: reset while BUSY with s_ack high.
        tick();
        check_eq("t6_idle", dbg_state, ST_IDLE);
        bus.m_req = 2'b01;
        tick();
        check_eq("t6_grant", bus.grant, 2'b01);
        rst       = 1'b1;
        bus.s_ack = 1'b1;
        #1;
        check_eq("t6_rst_m_ack", bus.m_ack, 0);
        check_eq("t6_rst_m_err", bus.m_err, 0);
        tick();
        bus.s_ack = 1'b0;
        check_eq("t6_rst_grant", bus.grant, 0);
        check_eq("t6_rst_s_req", bus.s_req, 0);
        check_eq("t6_rst_idx", bus.grant_idx, 0);
        check_eq("t6_rst_state", dbg_state, ST_IDLE);
        // Pointer reset makes m0 win even though m0 also won last.
        rst       = 1'b0;
        bus.m_req = 2'b11;
        tick();
        check_eq("t6_post_rst_grant", bus.grant, 2'b01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
